// File: rtl/csr_exe_ctrl_pkg.sv
// Shared types and constants for the CSR execute-stage controller.
// Holds the CSR op encodings and the result-queue entry layout.
package csr_exe_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_WARP   = 8;
    localparam int DEPTH_WARP = 3;
    localparam int RQ_DEPTH   = 2;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_W    = 2'b01,
        CSR_OP_S    = 2'b10,
        CSR_OP_C    = 2'b11
    } csr_op_e;

    typedef struct packed {
        logic [DEPTH_WARP-1:0] wid;
        logic [4:0]            rd;
        logic                  wxd;
        logic [XLEN-1:0]       data;
    } rq_entry_t;

    localparam int RQ_ENTRY_W = $bits(rq_entry_t);

endpackage

// File: rtl/csr_exe_ctrl_if.sv
// Bundle of the issue, CSR-file and writeback signals around csr_exe_ctrl.
// slave is the controller's view; master is the surrounding pipeline's view.
interface csr_exe_ctrl_if;
    import csr_exe_ctrl_pkg::*;

    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DEPTH_WARP-1:0] in_wid_i;
    logic [31:0]           in_inst_i;
    logic [1:0]            in_csr_i;
    logic                  in_custom_i;
    logic                  in_isvec_i;
    logic [XLEN-1:0]       in_rs1_i;
    logic                  in_wxd_i;
    logic [4:0]            in_rd_i;

    logic [DEPTH_WARP-1:0] csr_wid_o;
    logic [31:0]           csr_inst_o;
    logic [1:0]            csr_ctrl_o;
    logic                  csr_custom_o;
    logic                  csr_isvec_o;
    logic [XLEN-1:0]       csr_in1_o;
    logic                  csr_write_o;
    logic [XLEN-1:0]       csr_rdata_i;

    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DEPTH_WARP-1:0] out_wid_o;
    logic [4:0]            out_rd_o;
    logic                  out_wxd_o;
    logic [XLEN-1:0]       out_data_o;

    modport slave (
        input  in_valid_i, in_wid_i, in_inst_i, in_csr_i, in_custom_i,
               in_isvec_i, in_rs1_i, in_wxd_i, in_rd_i, csr_rdata_i, out_ready_i,
        output in_ready_o, csr_wid_o, csr_inst_o, csr_ctrl_o, csr_custom_o,
               csr_isvec_o, csr_in1_o, csr_write_o,
               out_valid_o, out_wid_o, out_rd_o, out_wxd_o, out_data_o
    );

    modport master (
        output in_valid_i, in_wid_i, in_inst_i, in_csr_i, in_custom_i,
               in_isvec_i, in_rs1_i, in_wxd_i, in_rd_i, csr_rdata_i, out_ready_i,
        input  in_ready_o, csr_wid_o, csr_inst_o, csr_ctrl_o, csr_custom_o,
               csr_isvec_o, csr_in1_o, csr_write_o,
               out_valid_o, out_wid_o, out_rd_o, out_wxd_o, out_data_o
    );

endinterface

// File: rtl/csr_result_fifo.sv
// Small synchronous FIFO with simultaneous push/pop; head is read directly
// from the storage array so a pushed entry is visible one cycle later.
module csr_result_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign dout  = mem_reg[rd_ptr_reg];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            count_reg <= count_next;
            if (push_ok) begin
                mem_reg[wr_ptr_reg] <= din;
                wr_ptr_reg          <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

endmodule

// File: rtl/csr_exe_ctrl.sv
// Execute-stage CSR controller: forwards each accepted op to the CSR file,
// strobes the commit once, and queues the pre-write rd value for writeback.
module csr_exe_ctrl
    import csr_exe_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    csr_exe_ctrl_if.slave bus
);

    localparam int CW = $clog2(RQ_DEPTH + 1);

    logic      fire;
    logic      pop;
    logic      rq_full;
    logic      rq_empty;
    logic [CW-1:0] rq_count;
    rq_entry_t push_entry;
    rq_entry_t head_entry;

    assign bus.csr_wid_o    = bus.in_wid_i;
    assign bus.csr_inst_o   = bus.in_inst_i;
    assign bus.csr_ctrl_o   = bus.in_csr_i;
    assign bus.csr_custom_o = bus.in_custom_i;
    assign bus.csr_isvec_o  = bus.in_isvec_i;
    assign bus.csr_in1_o    = bus.in_rs1_i;

    // Stalled requests never reach the CSR file: the commit strobe is gated by ready.
    assign bus.in_ready_o  = ~rst & ((rq_count < CW'(RQ_DEPTH)) | bus.out_ready_i);
    assign fire            = bus.in_valid_i & bus.in_ready_o;
    assign bus.csr_write_o = fire;

    assign bus.out_valid_o = ~rq_empty;
    assign pop             = bus.out_valid_o & bus.out_ready_i;

    // rd data is the value the CSR file shows before this cycle's commit.
    always_comb begin
        push_entry      = '0;
        push_entry.wid  = bus.in_wid_i;
        push_entry.rd   = bus.in_rd_i;
        push_entry.wxd  = bus.in_wxd_i;
        push_entry.data = bus.csr_rdata_i;
    end

    csr_result_fifo #(
        .WIDTH (RQ_ENTRY_W),
        .DEPTH (RQ_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srst  (rst),
        .push  (fire),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head_entry),
        .count (rq_count),
        .full  (rq_full),
        .empty (rq_empty)
    );

    assign bus.out_wid_o  = head_entry.wid;
    assign bus.out_rd_o   = head_entry.rd;
    assign bus.out_wxd_o  = head_entry.wxd;
    assign bus.out_data_o = head_entry.data;

    a_full_matches_count: assert property (
        @(posedge clk) disable iff (rst) rq_full |-> (rq_count == CW'(RQ_DEPTH))
    );

endmodule

// File: tb/tb_csr_exe_ctrl.sv
// Table-driven bench for csr_exe_ctrl with a writeback scoreboard,
// followed by a randomized valid/ready soak against the same scoreboard.
module tb_csr_exe_ctrl;
    import csr_exe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csr_exe_ctrl_if bus();

    csr_exe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit        rst;
        bit        valid;
        bit [2:0]  wid;
        bit [31:0] inst;
        bit [1:0]  csr;
        bit [31:0] rs1;
        bit        wxd;
        bit [4:0]  rd;
        bit [31:0] rdata;
        bit        out_ready;
        bit        exp_ready;
        bit        exp_write;
    } vec_t;

    int        checks = 0;
    int        errors = 0;
    rq_entry_t sb[$];
    vec_t      vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, bit v, bit [2:0] wid, bit [31:0] inst, bit [1:0] csr,
                                bit [31:0] rs1, bit wxd, bit [4:0] rd, bit [31:0] rdata,
                                bit oready, bit er, bit ew);
        vec_t t;
        t.rst = r; t.valid = v; t.wid = wid; t.inst = inst; t.csr = csr; t.rs1 = rs1;
        t.wxd = wxd; t.rd = rd; t.rdata = rdata; t.out_ready = oready;
        t.exp_ready = er; t.exp_write = ew;
        return t;
    endfunction

    task automatic run_cycle(input vec_t v, input int idx);
        bit accept;
        bit popm;
        rst             = v.rst;
        bus.in_valid_i  = v.valid;
        bus.in_wid_i    = v.wid;
        bus.in_inst_i   = v.inst;
        bus.in_csr_i    = v.csr;
        bus.in_custom_i = v.wid[0];
        bus.in_isvec_i  = v.rd[0];
        bus.in_rs1_i    = v.rs1;
        bus.in_wxd_i    = v.wxd;
        bus.in_rd_i     = v.rd;
        bus.csr_rdata_i = v.rdata;
        bus.out_ready_i = v.out_ready;
        @(negedge clk);
        check("in_ready", 64'(bus.in_ready_o), 64'(v.exp_ready));
        check("csr_write", 64'(bus.csr_write_o), 64'(v.exp_write));
        check("passthru", {bus.csr_wid_o, bus.csr_inst_o, bus.csr_ctrl_o, bus.csr_custom_o, bus.csr_isvec_o},
              {v.wid, v.inst, v.csr, v.wid[0], v.rd[0]});
        check("passthru_in1", 64'(bus.csr_in1_o), 64'(v.rs1));
        if (sb.size() > 0) begin
            check("out_valid", 64'(bus.out_valid_o), 64'(1));
            check("out_payload", 64'({bus.out_wid_o, bus.out_rd_o, bus.out_wxd_o, bus.out_data_o}), 64'(sb[0]));
        end else begin
            check("out_valid", 64'(bus.out_valid_o), 64'(0));
        end
        accept = !v.rst && v.valid && v.exp_ready;
        popm   = !v.rst && (sb.size() > 0) && v.out_ready;
        @(posedge clk);
        #1;
        if (v.rst) begin
            if (sb.size() > 0) $display("cyc %0d reset discards %0d queued entries", idx, sb.size());
            sb.delete();
        end else begin
            if (popm) begin
                $display("cyc %0d retire wid=%0d rd=%0d wxd=%0d data=%08h",
                         idx, sb[0].wid, sb[0].rd, sb[0].wxd, sb[0].data);
                void'(sb.pop_front());
            end
            if (accept) begin
                $display("cyc %0d accept wid=%0d rd=%0d csr=%0d rdata=%08h",
                         idx, v.wid, v.rd, v.csr, v.rdata);
                sb.push_back('{wid: v.wid, rd: v.rd, wxd: v.wxd, data: v.rdata});
            end
        end
    endtask

    localparam bit [31:0] I_MSCR = {12'h305, 5'd1, 3'b001, 5'd5, 7'h73};
    localparam bit [31:0] I_MST  = {12'h300, 5'd1, 3'b001, 5'd0, 7'h73};

    initial begin
        vec_t v;
        rst = 1'b1;
        bus.in_valid_i = 1'b0; bus.in_wid_i = '0; bus.in_inst_i = '0; bus.in_csr_i = '0;
        bus.in_custom_i = 1'b0; bus.in_isvec_i = 1'b0; bus.in_rs1_i = '0; bus.in_wxd_i = 1'b0;
        bus.in_rd_i = '0; bus.csr_rdata_i = '0; bus.out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        //           rst v  wid inst    csr    rs1    wxd rd  rdata     ordy rdy wr
        vecs.push_back(mk(1, 1, 0, 0,      2'b00, 0,     0,  0,  0,        0,  0,  0));
        vecs.push_back(mk(1, 0, 0, 0,      2'b00, 0,     0,  0,  0,        0,  0,  0));
        vecs.push_back(mk(0, 0, 0, 0,      2'b00, 0,     0,  0,  0,        0,  1,  0));
        vecs.push_back(mk(0, 1, 3, I_MSCR, 2'b01, 'hA5, 1,  5,  'h11,     1,  1,  1));
        vecs.push_back(mk(0, 0, 0, 0,      2'b00, 0,     0,  0,  0,        1,  1,  0));
        vecs.push_back(mk(0, 1, 1, I_MSCR, 2'b01, 'h1,  1,  1,  'h100,    0,  1,  1));
        vecs.push_back(mk(0, 1, 2, I_MSCR, 2'b10, 'h2,  1,  2,  'h200,    0,  1,  1));
        vecs.push_back(mk(0, 1, 4, I_MSCR, 2'b11, 'h3,  1,  3,  'h300,    0,  0,  0));
        vecs.push_back(mk(0, 1, 4, I_MSCR, 2'b11, 'h3,  1,  3,  'h300,    0,  0,  0));
        vecs.push_back(mk(0, 1, 4, I_MSCR, 2'b11, 'h3,  1,  3,  'h300,    1,  1,  1));
        vecs.push_back(mk(0, 1, 5, I_MSCR, 2'b01, 'h4,  1,  7,  'h400,    1,  1,  1));
        vecs.push_back(mk(0, 1, 6, I_MST,  2'b01, 'h8,  0,  0,  'h1800,   1,  1,  1));
        vecs.push_back(mk(0, 0, 0, 0,      2'b00, 0,     0,  0,  0,        1,  1,  0));
        vecs.push_back(mk(0, 0, 0, 0,      2'b00, 0,     0,  0,  0,        0,  1,  0));
        vecs.push_back(mk(0, 0, 0, 0,      2'b00, 0,     0,  0,  0,        0,  1,  0));
        vecs.push_back(mk(0, 1, 0, I_MSCR, 2'b01, 'h9,  1,  4,  'h55,     0,  1,  1));
        vecs.push_back(mk(1, 1, 0, I_MSCR, 2'b01, 'h9,  1,  4,  'h55,     0,  0,  0));
        vecs.push_back(mk(0, 0, 0, 0,      2'b00, 0,     0,  0,  0,        0,  1,  0));
        vecs.push_back(mk(0, 1, 7, I_MSCR, 2'b10, 'hF0, 1,  9,  'hCAFE,   0,  1,  1));
        vecs.push_back(mk(0, 0, 0, 0,      2'b00, 0,     0,  0,  0,        1,  1,  0));
        vecs.push_back(mk(0, 0, 0, 0,      2'b00, 0,     0,  0,  0,        1,  1,  0));

        for (int i = 0; i < vecs.size(); i++) begin
            run_cycle(vecs[i], i);
            if (i == 1) begin
                check("reset_payload", 64'({bus.out_wid_o, bus.out_rd_o, bus.out_wxd_o, bus.out_data_o}), 64'(0));
            end
        end

        // Randomized soak: valid/ready toggling against the scoreboard.
        for (int i = 0; i < 200; i++) begin
            v.rst       = 1'b0;
            v.valid     = 1'($urandom_range(0, 1));
            v.wid       = 3'($urandom_range(0, 7));
            v.inst      = $urandom;
            v.csr       = 2'($urandom_range(0, 3));
            v.rs1       = $urandom;
            v.wxd       = 1'($urandom_range(0, 1));
            v.rd        = 5'($urandom_range(0, 31));
            v.rdata     = $urandom;
            v.out_ready = 1'($urandom_range(0, 1));
            v.exp_ready = (sb.size() < RQ_DEPTH) || v.out_ready;
            v.exp_write = v.valid && v.exp_ready;
            run_cycle(v, 100 + i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
